gmem_axi_read_responder: RTL and testbench

AXI4 read-channel responder (slave end) that answers AR requests from an HLS `m_axi` read adapter with INCR bursts of R beats, served from an internal word-addressed memory. It is used as the memory-side endpoint in block-level benches and stand-alone kernel builds, facing the `out_BUS_AR*` / `in_BUS_R*` ports of a gmem master. Up to `NUM_OUTSTANDING` requests are queued, and bursts are returned strictly in order with full RREADY backpressure.

---
 rtl/gmem_axi_read_responder_pkg.sv | 23 ++
 rtl/gmem_axi_rd_req_fifo.sv | 66 ++++++
 rtl/gmem_axi_read_responder.sv | 136 +++++++++++++
 tb/tb_gmem_axi_read_responder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmem_axi_read_responder_pkg.sv
// Shared constants, FSM encoding and helpers for the gmem AXI read responder.
package gmem_axi_read_responder_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR   = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Ceiling log2, used for elaboration-time widths only.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gmem_axi_rd_req_fifo.sv
// Synchronous request FIFO with a registered output stage; empty_n means dout holds a valid entry.
module gmem_axi_rd_req_fifo
    import gmem_axi_read_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  ce,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full_n,
    input  logic                  read,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty_n
);

    localparam int PW = log2(DEPTH);

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [PW:0]           mem_used;
    logic [PW:0]           count;
    logic [PW:0]           count_next;
    logic                  push;
    logic                  pop;
    logic                  load_out;

    assign push       = ce & write & full_n;
    assign pop        = ce & read & empty_n;
    // The output stage refills from storage whenever it is empty or being drained.
    assign load_out   = ce & (mem_used != '0) & (~empty_n | pop);
    assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

    // NOTE: storage is deliberately not reset; only pointers and flags need a known state.
    always_ff @(posedge ACLK) begin
        if (push) store[wptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wptr     <= '0;
            rptr     <= '0;
            mem_used <= '0;
            count    <= '0;
            full_n   <= 1'b0;
            empty_n  <= 1'b0;
            dout     <= '0;
        end else if (ce) begin
            if (push) wptr <= wptr + 1'b1;
            if (load_out) begin
                dout <= store[rptr];
                rptr <= rptr + 1'b1;
            end
            if (load_out)  empty_n <= 1'b1;
            else if (pop)  empty_n <= 1'b0;
            mem_used <= mem_used + (PW+1)'(push) - (PW+1)'(load_out);
            count    <= count_next;
            full_n   <= (count_next != (PW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/gmem_axi_read_responder.sv
// AXI4 read responder: queues AR requests and returns in-order INCR bursts from an internal word memory.
module gmem_axi_read_responder
    import gmem_axi_read_responder_pkg::*;
#(
    parameter int C_ID_WIDTH      = 1,
    parameter int C_USER_WIDTH    = 1,
    parameter int BUS_ADDR_WIDTH  = 32,
    parameter int BUS_DATA_WIDTH  = 32,
    parameter int MEM_DEPTH       = 1024,
    parameter int NUM_OUTSTANDING = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic                       ACLK_EN,
    input  logic [C_ID_WIDTH-1:0]      in_BUS_ARID,
    input  logic [BUS_ADDR_WIDTH-1:0]  in_BUS_ARADDR,
    input  logic [7:0]                 in_BUS_ARLEN,
    input  logic [2:0]                 in_BUS_ARSIZE,
    input  logic [1:0]                 in_BUS_ARBURST,
    input  logic                       in_BUS_ARVALID,
    output logic                       out_BUS_ARREADY,
    output logic [C_ID_WIDTH-1:0]      out_BUS_RID,
    output logic [BUS_DATA_WIDTH-1:0]  out_BUS_RDATA,
    output logic [1:0]                 out_BUS_RRESP,
    output logic                       out_BUS_RLAST,
    output logic [C_USER_WIDTH-1:0]    out_BUS_RUSER,
    output logic                       out_BUS_RVALID,
    input  logic                       in_BUS_RREADY,
    input  logic                       in_MEM_WE,
    input  logic [log2(MEM_DEPTH)-1:0] in_MEM_WADDR,
    input  logic [BUS_DATA_WIDTH-1:0]  in_MEM_WDATA
);

    localparam int ALIGN = log2(BUS_DATA_WIDTH / 8);
    localparam int AW    = log2(MEM_DEPTH);
    localparam int QW    = C_ID_WIDTH + AW + 8 + 1;

    logic [BUS_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [BUS_ADDR_WIDTH-1:0] ar_word;
    logic [BUS_ADDR_WIDTH:0]   ar_end;
    logic                      ar_err;
    logic [QW-1:0]             q_din;
    logic [QW-1:0]             q_dout;
    logic                      q_full_n;
    logic                      q_empty_n;
    logic                      q_read;
    logic [C_ID_WIDTH-1:0]     q_id;
    logic [AW-1:0]             q_addr;
    logic [7:0]                q_len;
    logic                      q_err;

    state_t                    state;
    logic [AW-1:0]             beat_addr;
    logic [7:0]                beats_left;
    logic                      cur_err;
    logic                      r_hs;
    logic                      load;
    logic [AW-1:0]             rd_addr;
    logic [BUS_DATA_WIDTH-1:0] rd_word;

    // End index is formed one bit wider so requests running past the top of memory are caught.
    assign ar_word = in_BUS_ARADDR >> ALIGN;
    assign ar_end  = {1'b0, ar_word} + (BUS_ADDR_WIDTH+1)'(in_BUS_ARLEN);
    assign ar_err  = (in_BUS_ARBURST != BURST_INCR) || (in_BUS_ARSIZE != 3'(ALIGN)) ||
                     (ar_end >= (BUS_ADDR_WIDTH+1)'(MEM_DEPTH));
    assign q_din   = {in_BUS_ARID, ar_word[AW-1:0], in_BUS_ARLEN, ar_err};
    assign {q_id, q_addr, q_len, q_err} = q_dout;

    gmem_axi_rd_req_fifo #(
        .DATA_WIDTH (QW),
        .DEPTH      (NUM_OUTSTANDING)
    ) u_req_fifo (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .ce      (ACLK_EN),
        .write   (in_BUS_ARVALID),
        .din     (q_din),
        .full_n  (q_full_n),
        .read    (q_read),
        .dout    (q_dout),
        .empty_n (q_empty_n)
    );

    assign out_BUS_ARREADY = q_full_n;
    assign out_BUS_RUSER   = '0;

    // A new burst starts from IDLE or on the final beat handshake, giving back-to-back bursts.
    assign r_hs    = out_BUS_RVALID & in_BUS_RREADY;
    assign q_read  = (state == IDLE) || (r_hs && beats_left == 8'd0);
    assign load    = ACLK_EN & q_read & q_empty_n;
    assign rd_addr = load ? q_addr : beat_addr;
    assign rd_word = mem[rd_addr];

    always_ff @(posedge ACLK) begin
        if (ACLK_EN && in_MEM_WE) mem[in_MEM_WADDR] <= in_MEM_WDATA;
    end

    // beat_addr/beats_left describe the beat after the one currently presented on R.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state          <= IDLE;
            beat_addr      <= '0;
            beats_left     <= '0;
            cur_err        <= 1'b0;
            out_BUS_RVALID <= 1'b0;
            out_BUS_RLAST  <= 1'b0;
            out_BUS_RDATA  <= '0;
            out_BUS_RRESP  <= RRESP_OKAY;
            out_BUS_RID    <= '0;
        end else if (ACLK_EN) begin
            if (load) begin
                state          <= BURST;
                beat_addr      <= q_addr + 1'b1;
                beats_left     <= q_len;
                cur_err        <= q_err;
                out_BUS_RVALID <= 1'b1;
                out_BUS_RLAST  <= (q_len == 8'd0);
                out_BUS_RDATA  <= q_err ? '0 : rd_word;
                out_BUS_RRESP  <= q_err ? RRESP_SLVERR : RRESP_OKAY;
                out_BUS_RID    <= q_id;
            end else if (r_hs) begin
                if (beats_left != 8'd0) begin
                    beat_addr     <= beat_addr + 1'b1;
                    beats_left    <= beats_left - 8'd1;
                    out_BUS_RLAST <= (beats_left == 8'd1);
                    out_BUS_RDATA <= cur_err ? '0 : rd_word;
                end else begin
                    state          <= IDLE;
                    out_BUS_RVALID <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gmem_axi_read_responder.sv
// Directed bench for gmem_axi_read_responder: bursts, queueing, backpressure, errors, collision, reset.
module tb_gmem_axi_read_responder;

    logic        ACLK;
    logic        ARESETN;
    logic        ACLK_EN;
    logic [1:0]  in_BUS_ARID;
    logic [31:0] in_BUS_ARADDR;
    logic [7:0]  in_BUS_ARLEN;
    logic [2:0]  in_BUS_ARSIZE;
    logic [1:0]  in_BUS_ARBURST;
    logic        in_BUS_ARVALID;
    logic        out_BUS_ARREADY;
    logic [1:0]  out_BUS_RID;
    logic [31:0] out_BUS_RDATA;
    logic [1:0]  out_BUS_RRESP;
    logic        out_BUS_RLAST;
    logic [0:0]  out_BUS_RUSER;
    logic        out_BUS_RVALID;
    logic        in_BUS_RREADY;
    logic        in_MEM_WE;
    logic [9:0]  in_MEM_WADDR;
    logic [31:0] in_MEM_WDATA;

    int checks;
    int failures;

    gmem_axi_read_responder #(
        .C_ID_WIDTH      (2),
        .C_USER_WIDTH    (1),
        .BUS_ADDR_WIDTH  (32),
        .BUS_DATA_WIDTH  (32),
        .MEM_DEPTH       (1024),
        .NUM_OUTSTANDING (4)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .ACLK_EN         (ACLK_EN),
        .in_BUS_ARID     (in_BUS_ARID),
        .in_BUS_ARADDR   (in_BUS_ARADDR),
        .in_BUS_ARLEN    (in_BUS_ARLEN),
        .in_BUS_ARSIZE   (in_BUS_ARSIZE),
        .in_BUS_ARBURST  (in_BUS_ARBURST),
        .in_BUS_ARVALID  (in_BUS_ARVALID),
        .out_BUS_ARREADY (out_BUS_ARREADY),
        .out_BUS_RID     (out_BUS_RID),
        .out_BUS_RDATA   (out_BUS_RDATA),
        .out_BUS_RRESP   (out_BUS_RRESP),
        .out_BUS_RLAST   (out_BUS_RLAST),
        .out_BUS_RUSER   (out_BUS_RUSER),
        .out_BUS_RVALID  (out_BUS_RVALID),
        .in_BUS_RREADY   (in_BUS_RREADY),
        .in_MEM_WE       (in_MEM_WE),
        .in_MEM_WADDR    (in_MEM_WADDR),
        .in_MEM_WDATA    (in_MEM_WDATA)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic preload(input logic [9:0] addr, input logic [31:0] data);
        in_MEM_WE    = 1'b1;
        in_MEM_WADDR = addr;
        in_MEM_WDATA = data;
        tick();
        in_MEM_WE    = 1'b0;
    endtask

    // Returns one sample after the handshake edge.
    task automatic ar_send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done           = 1'b0;
        in_BUS_ARID    = id;
        in_BUS_ARADDR  = addr;
        in_BUS_ARLEN   = len;
        in_BUS_ARSIZE  = size;
        in_BUS_ARBURST = burst;
        in_BUS_ARVALID = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            done = out_BUS_ARREADY;
            tick();
        end
        in_BUS_ARVALID = 1'b0;
        check("ar_accept", 64'(done), 64'd1);
    endtask

    // Expects a full burst with RREADY held high; data increments from base unless err.
    task automatic expect_burst(input string tag, input int nbeats, input logic [31:0] base,
                                input bit err, input logic [1:0] id);
        in_BUS_RREADY = 1'b1;
        for (int c = 0; c < 16 && !out_BUS_RVALID; c++) tick();
        for (int i = 0; i < nbeats; i++) begin
            check({tag, "_rvalid"}, 64'(out_BUS_RVALID), 64'd1);
            check({tag, "_rdata"}, 64'(out_BUS_RDATA), err ? 64'd0 : 64'(base + 32'(i)));
            check({tag, "_rresp"}, 64'(out_BUS_RRESP), err ? 64'd2 : 64'd0);
            check({tag, "_rlast"}, 64'(out_BUS_RLAST), 64'(i == nbeats - 1));
            check({tag, "_rid"}, 64'(out_BUS_RID), 64'(id));
            tick();
        end
        check({tag, "_end_idle"}, 64'(out_BUS_RVALID), 64'd0);
    endtask

    initial begin
        logic [63:0] snap;
        bit          hs;
        bit          was_valid;
        int          n;

        checks         = 0;
        failures       = 0;
        ARESETN        = 1'b0;
        ACLK_EN        = 1'b1;
        in_BUS_ARID    = '0;
        in_BUS_ARADDR  = '0;
        in_BUS_ARLEN   = '0;
        in_BUS_ARSIZE  = '0;
        in_BUS_ARBURST = '0;
        in_BUS_ARVALID = 1'b0;
        in_BUS_RREADY  = 1'b0;
        in_MEM_WE      = 1'b0;
        in_MEM_WADDR   = '0;
        in_MEM_WDATA   = '0;

        // Reset state
        tick();
        tick();
        check("rst_arready", 64'(out_BUS_ARREADY), 64'd0);
        check("rst_rvalid", 64'(out_BUS_RVALID), 64'd0);
        check("rst_rlast", 64'(out_BUS_RLAST), 64'd0);
        check("rst_rdata", 64'(out_BUS_RDATA), 64'd0);
        check("rst_rresp", 64'(out_BUS_RRESP), 64'd0);
        check("rst_rid", 64'(out_BUS_RID), 64'd0);
        ARESETN = 1'b1;
        tick();
        check("post_rst_arready", 64'(out_BUS_ARREADY), 64'd1);
        check("ruser_zero", 64'(out_BUS_RUSER), 64'd0);

        for (int i = 0; i < 16; i++) preload(10'(i), 32'h100 + 32'(i));
        preload(10'd1023, 32'hABC);

        // Single burst with latency check
        in_BUS_RREADY = 1'b1;
        ar_send(2'd0, 32'h0, 8'd7, 3'd2, 2'b01);
        check("lat_t0", 64'(out_BUS_RVALID), 64'd0);
        tick();
        check("lat_t1", 64'(out_BUS_RVALID), 64'd0);
        tick();
        check("lat_t2", 64'(out_BUS_RVALID), 64'd1);
        expect_burst("single", 8, 32'h100, 1'b0, 2'd0);

        // Clock enable low holds the presented beat
        ar_send(2'd1, 32'h0, 8'd3, 3'd2, 2'b01);
        tick();
        tick();
        ACLK_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_hold_rvalid", 64'(out_BUS_RVALID), 64'd1);
            check("ce_hold_rdata", 64'(out_BUS_RDATA), 64'h100);
        end
        ACLK_EN = 1'b1;
        expect_burst("ce_resume", 4, 32'h100, 1'b0, 2'd1);

        // Back-to-back: four queued bursts drain with no idle cycle
        in_BUS_RREADY = 1'b0;
        for (int i = 0; i < 4; i++) ar_send(2'(i), 32'(i * 16), 8'd3, 3'd2, 2'b01);
        in_BUS_RREADY = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("b2b_rvalid", 64'(out_BUS_RVALID), 64'd1);
            check("b2b_rid", 64'(out_BUS_RID), 64'(i / 4));
            check("b2b_rdata", 64'(out_BUS_RDATA), 64'(32'h100 + 32'(i)));
            check("b2b_rlast", 64'(out_BUS_RLAST), 64'((i % 4) == 3));
            tick();
        end
        check("b2b_end_idle", 64'(out_BUS_RVALID), 64'd0);

        // Hold-off: four queued plus one in service fills the block
        in_BUS_RREADY = 1'b0;
        for (int i = 0; i < 5; i++) ar_send(2'(i % 4), 32'(i * 4), 8'd0, 3'd2, 2'b01);
        check("full_arready", 64'(out_BUS_ARREADY), 64'd0);
        check("full_rdata", 64'(out_BUS_RDATA), 64'h100);
        in_BUS_ARID    = 2'd1;
        in_BUS_ARADDR  = 32'd20;
        in_BUS_ARLEN   = 8'd0;
        in_BUS_ARSIZE  = 3'd2;
        in_BUS_ARBURST = 2'b01;
        in_BUS_ARVALID = 1'b1;
        tick();
        check("full_hold_arready", 64'(out_BUS_ARREADY), 64'd0);
        check("full_hold_rid", 64'(out_BUS_RID), 64'd0);
        in_BUS_RREADY = 1'b1;
        tick();
        check("pop_frees_arready", 64'(out_BUS_ARREADY), 64'd1);
        check("pop_rdata", 64'(out_BUS_RDATA), 64'h101);
        tick();
        in_BUS_ARVALID = 1'b0;
        for (int i = 2; i < 6; i++) begin
            check("holdoff_rvalid", 64'(out_BUS_RVALID), 64'd1);
            check("holdoff_rdata", 64'(out_BUS_RDATA), 64'(32'h100 + 32'(i)));
            check("holdoff_rid", 64'(out_BUS_RID), 64'(i % 4));
            tick();
        end
        check("holdoff_end_idle", 64'(out_BUS_RVALID), 64'd0);

        // Backpressure: random RREADY over a 16-beat burst
        in_BUS_RREADY = 1'b0;
        ar_send(2'd2, 32'h0, 8'd15, 3'd2, 2'b01);
        n = 0;
        for (int c = 0; c < 400 && n < 16; c++) begin
            if (out_BUS_RVALID) begin
                check("bp_rdata", 64'(out_BUS_RDATA), 64'(32'h100 + 32'(n)));
                check("bp_rlast", 64'(out_BUS_RLAST), 64'(n == 15));
            end
            in_BUS_RREADY = 1'($urandom_range(0, 1));
            was_valid     = out_BUS_RVALID;
            hs            = out_BUS_RVALID && in_BUS_RREADY;
            snap          = {27'd0, out_BUS_RDATA, out_BUS_RLAST, out_BUS_RRESP, out_BUS_RID};
            tick();
            if (hs) n++;
            else if (was_valid) begin
                check("bp_stable_rvalid", 64'(out_BUS_RVALID), 64'd1);
                check("bp_stable_payload",
                      {27'd0, out_BUS_RDATA, out_BUS_RLAST, out_BUS_RRESP, out_BUS_RID}, snap);
            end
        end
        check("bp_handshakes", 64'(n), 64'd16);
        check("bp_end_idle", 64'(out_BUS_RVALID), 64'd0);
        in_BUS_RREADY = 1'b1;
        tick();
        check("bp_no_extra", 64'(out_BUS_RVALID), 64'd0);

        // Error bursts and the memory-top boundary
        ar_send(2'd3, 32'h0, 8'd2, 3'd2, 2'b10);
        expect_burst("err_burst", 3, 32'h0, 1'b1, 2'd3);
        ar_send(2'd1, 32'h0, 8'd0, 3'd1, 2'b01);
        expect_burst("err_size", 1, 32'h0, 1'b1, 2'd1);
        ar_send(2'd2, 32'(1022 << 2), 8'd3, 3'd2, 2'b01);
        expect_burst("err_range", 4, 32'h0, 1'b1, 2'd2);
        ar_send(2'd0, 32'(1023 << 2), 8'd0, 3'd2, 2'b01);
        expect_burst("top_word", 1, 32'hABC, 1'b0, 2'd0);

        // Preload collision: the beat for word 5 is loaded at the same edge as the write
        in_BUS_RREADY = 1'b1;
        ar_send(2'd0, 32'h0, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 6; i++) tick();
        check("coll_beat4", 64'(out_BUS_RDATA), 64'h104);
        in_MEM_WE    = 1'b1;
        in_MEM_WADDR = 10'd5;
        in_MEM_WDATA = 32'hDEAD;
        tick();
        in_MEM_WE = 1'b0;
        check("coll_old_data", 64'(out_BUS_RDATA), 64'h105);
        tick();
        check("coll_beat6", 64'(out_BUS_RDATA), 64'h106);
        tick();
        check("coll_beat7_last", 64'(out_BUS_RLAST), 64'd1);
        tick();
        check("coll_end_idle", 64'(out_BUS_RVALID), 64'd0);
        ar_send(2'd1, 32'd20, 8'd0, 3'd2, 2'b01);
        expect_burst("coll_new_data", 1, 32'hDEAD, 1'b0, 2'd1);

        // Reset mid-burst with a second request queued
        ar_send(2'd0, 32'h0, 8'd7, 3'd2, 2'b01);
        ar_send(2'd1, 32'd16, 8'd0, 3'd2, 2'b01);
        tick();
        tick();
        tick();
        check("rstmid_beat2", 64'(out_BUS_RDATA), 64'h102);
        #2;
        ARESETN = 1'b0;
        #1;
        check("rstmid_rvalid_async", 64'(out_BUS_RVALID), 64'd0);
        check("rstmid_arready", 64'(out_BUS_ARREADY), 64'd0);
        tick();
        tick();
        ARESETN = 1'b1;
        tick();
        check("rstmid_arready_back", 64'(out_BUS_ARREADY), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check("rstmid_queue_flushed", 64'(out_BUS_RVALID), 64'd0);
            tick();
        end
        ar_send(2'd3, 32'd32, 8'd1, 3'd2, 2'b01);
        expect_burst("rstmid_new", 2, 32'h108, 1'b0, 2'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
